// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: periodic cs/sclk frame scheduler and serial capture for a 12-bit PMOD ADC.
// Latency: result visible 32*CLK_DIV+1 cycles after cs falls; cs returns high at 33*CLK_DIV.
// Backpressure: none toward the ADC; an untaken result is overwritten and flagged via sticky overrun.
//
// Ports:
//   clk, rst (async, active-low), en (run periodic conversions), clr_ovr (clear overrun pulse)
//   sdata (ADC serial data, MSB first), cs (active-low chip select), sclk (idles high)
//   sample/sample_valid/sample_ready (result handshake), overrun (sticky), busy (frame in progress)
//
// Optional feature: define ADC_AVG_EN to average every 4 frames into one result (14-bit sum >> 2).

module adc_frame_sequencer #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_ovr,
    input  logic                 sdata,
    output logic                 cs,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAST_HALF = 2 * FRAME_BITS;
    localparam int HALF_W    = $clog2(LAST_HALF + 1);
    localparam int HOLD_W    = $clog2(2 * CLK_DIV);
    localparam int TMR_W     = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]     div_cnt;
    logic [HALF_W-1:0]    half_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [TMR_W-1:0]     timer;
    logic                 pending;
    logic [DATA_BITS-2:0] shreg;

    logic                 tick, start, div_last, conv_end, hold_end;
    logic                 bit_strobe, frame_done;
    logic [DATA_BITS-1:0] frame_result;
    logic                 cs_nxt, sclk_nxt;
    logic                 res_evt;
    logic [DATA_BITS-1:0] res_dat;

    assign tick     = en && (timer == '0);
    assign start    = (state == IDLE) && en && (tick || pending);
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign conv_end = (state == CONV) && div_last && (half_cnt == HALF_W'(LAST_HALF));
    assign hold_end = (state == HOLD) && (hold_cnt == HOLD_W'(2 * CLK_DIV - 1));

    // half_cnt counts sclk half-periods; even non-zero values are high phases,
    // and the first cycle of each is the rising edge where sdata is captured.
    assign bit_strobe = (state == CONV) && (div_cnt == '0) && !half_cnt[0] && (half_cnt != '0);
    assign frame_done = bit_strobe && (half_cnt == HALF_W'(LAST_HALF));

    // The shift register keeps only DATA_BITS-1 bits, so the leading zero bits
    // fall off the top naturally; the final bit joins straight from sdata.
    assign frame_result = {shreg, sdata};
    assign busy         = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = CONV;
            CONV:    if (conv_end) state_nxt = HOLD;
            HOLD:    if (hold_end) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered cs/sclk pins
    always_comb begin
        cs_nxt   = 1'b1;
        sclk_nxt = 1'b1;
        case (state)
            IDLE: cs_nxt = !start;
            CONV: begin
                cs_nxt = conv_end;
                if (conv_end)      sclk_nxt = 1'b1;
                else if (div_last) sclk_nxt = half_cnt[0]; // entering odd half -> low
                else               sclk_nxt = sclk;
            end
            default: ;
        endcase
    end

    // Frame timing, period scheduling and serial capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs       <= 1'b1;
            sclk     <= 1'b1;
            div_cnt  <= '0;
            half_cnt <= '0;
            hold_cnt <= '0;
            timer    <= '0;
            pending  <= 1'b0;
            shreg    <= '0;
        end else begin
            cs   <= cs_nxt;
            sclk <= sclk_nxt;

            if (state == CONV && !div_last) div_cnt <= div_cnt + DIV_W'(1);
            else                            div_cnt <= '0;

            if (state != CONV || conv_end) half_cnt <= '0;
            else if (div_last)             half_cnt <= half_cnt + HALF_W'(1);

            if (state == HOLD && !hold_end) hold_cnt <= hold_cnt + HOLD_W'(1);
            else                            hold_cnt <= '0;

            // Period timer free-runs through CONV/HOLD so the sample rate stays fixed
            if (!en)                                     timer <= '0;
            else if (timer == TMR_W'(SAMPLE_PERIOD - 1)) timer <= '0;
            else                                         timer <= timer + TMR_W'(1);

            // One pending start at most; extra ticks during a frame are dropped
            if (!en)                              pending <= 1'b0;
            else if (start)                       pending <= 1'b0;
            else if (tick && state != IDLE)       pending <= 1'b1;

            if (bit_strobe) shreg <= frame_result[DATA_BITS-2:0];
        end
    end

`ifdef ADC_AVG_EN
    localparam int ACC_W = DATA_BITS + 2;

    logic [ACC_W-1:0] acc, acc_sum;
    logic [1:0]       avg_cnt;

    assign acc_sum = acc + ACC_W'(frame_result);
    assign res_evt = frame_done && en && (avg_cnt == 2'd3);
    assign res_dat = DATA_BITS'(acc_sum >> 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (!en) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (frame_done) begin
            if (avg_cnt == 2'd3) begin
                acc     <= '0;
                avg_cnt <= '0;
            end else begin
                acc     <= acc_sum;
                avg_cnt <= avg_cnt + 2'd1;
            end
        end
    end
`else
    assign res_evt = frame_done;
    assign res_dat = frame_result;
`endif

    // Result handshake; a new result always wins over a same-cycle accept,
    // and overrun only fires when the old value was genuinely left untaken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (res_evt) begin
                sample       <= res_dat;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (res_evt && sample_valid && !sample_ready) overrun <= 1'b1;
            else if (clr_ovr)                             overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer: directed bench for adc_frame_sequencer with CLK_DIV=2.
// Main instance uses SAMPLE_PERIOD=100; a second instance uses 40 for back-to-back frames.
// A small ADC model shifts a 16-bit word out on sclk falling edges, MSB first.

module tb_adc_frame_sequencer;

    logic        clk;
    logic        rst;
    logic        en, clr_ovr, sdata, sample_ready;
    logic        cs, sclk, sample_valid, overrun, busy;
    logic [11:0] sample;

    logic        en_b;
    logic        cs_b, sclk_b, valid_b, overrun_b, busy_b;
    logic [11:0] sample_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] adc_word;
    int          adc_rises;
    logic        prev_cs, prev_sclk;

    adc_frame_sequencer #(
        .CLK_DIV(2), .FRAME_BITS(16), .DATA_BITS(12), .SAMPLE_PERIOD(100)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr_ovr(clr_ovr), .sdata(sdata),
        .cs(cs), .sclk(sclk), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun), .busy(busy)
    );

    adc_frame_sequencer #(
        .CLK_DIV(2), .FRAME_BITS(16), .DATA_BITS(12), .SAMPLE_PERIOD(40)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .clr_ovr(1'b0), .sdata(1'b0),
        .cs(cs_b), .sclk(sclk_b), .sample(sample_b), .sample_valid(valid_b),
        .sample_ready(1'b1), .overrun(overrun_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: bit 15 presented at cs fall, next bit after every sclk fall
    // that follows a rise, so the DUT sees each bit stable on its rising edge.
    always @(negedge clk) begin
        logic [3:0] idx;
        if (prev_cs === 1'b1 && cs === 1'b0) begin
            adc_rises = 0;
            sdata = adc_word[15];
        end
        if (cs === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) adc_rises = adc_rises + 1;
        if (cs === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0 && adc_rises < 16) begin
            idx = 4'(15 - adc_rises);
            sdata = adc_word[idx];
        end
        prev_cs   = cs;
        prev_sclk = sclk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; en_b = 1'b0; clr_ovr = 1'b0; sample_ready = 1'b0;
        adc_word = 16'h0000; sdata = 1'b0; adc_rises = 0;
        step(3);
        n_checks++;
        if ({cs, sclk, sample_valid, overrun, busy} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_ctrl: cs/sclk/valid/ovr/busy=%b expected 11000",
                     {cs, sclk, sample_valid, overrun, busy});
        end
        n_checks++;
        if (sample !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_sample: got %h expected 000", sample);
        end
        @(negedge clk);
        rst = 1'b1;
        step(10);
        n_checks++;
        if ({cs, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_en0: cs/busy=%b expected 10", {cs, busy});
        end
    endtask

    task automatic test_basic_frame;
        logic exp_cs, exp_sclk;
        int   bad;
        adc_word = 16'h0AC3;
        sample_ready = 1'b0;
        en = 1'b1;
        step(1);                       // cycle T
        bad = 0;
        for (int c = 0; c <= 66; c++) begin
            exp_cs   = (c >= 66);
            exp_sclk = (c >= 66) ? 1'b1 : (((c / 2) % 2) == 0);
            if ({cs, sclk} !== {exp_cs, exp_sclk}) begin
                bad++;
                $display("FAIL frame_wave c=%0d: cs/sclk=%b expected %b", c, {cs, sclk}, {exp_cs, exp_sclk});
            end
            if (c == 64) begin
                n_checks++;
                if (sample_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_early: valid=%b at T+64 expected 0", sample_valid);
                end
            end
            if (c == 65) begin
                n_checks++;
                if ({sample_valid, sample} !== {1'b1, 12'hAC3}) begin
                    n_fail++;
                    $display("FAIL result_AC3: valid/sample=%b/%h expected 1/ac3", sample_valid, sample);
                end
            end
            if (c == 66) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_hold: busy=%b expected 1", busy);
                end
            end
            if (c < 66) step(1);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL frame_wave_total: %0d bad cycles expected 0", bad);
        end
        en = 1'b0;
        step(4);                       // T+70, HOLD over
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_idle: busy=%b expected 0", busy);
        end
        sample_ready = 1'b1;
        step(1);
        sample_ready = 1'b0;
        n_checks++;
        if ({sample_valid, sample} !== {1'b0, 12'hAC3}) begin
            n_fail++;
            $display("FAIL accept: valid/sample=%b/%h expected 0/ac3", sample_valid, sample);
        end
    endtask

    task automatic test_overrun;
        adc_word = 16'h0123;
        sample_ready = 1'b0;
        en = 1'b1;
        step(1);                       // T
        step(65);
        n_checks++;
        if ({sample_valid, overrun, sample} !== {2'b10, 12'h123}) begin
            n_fail++;
            $display("FAIL ovr_first: valid/ovr/sample=%b/%b/%h expected 1/0/123", sample_valid, overrun, sample);
        end
        adc_word = 16'h0FFF;
        step(100);                     // T+165
        n_checks++;
        if ({sample_valid, overrun, sample} !== {2'b11, 12'hFFF}) begin
            n_fail++;
            $display("FAIL ovr_second: valid/ovr/sample=%b/%b/%h expected 1/1/fff", sample_valid, overrun, sample);
        end
        en = 1'b0;
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        n_checks++;
        if ({overrun, sample_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovr_clear: ovr/valid=%b expected 01", {overrun, sample_valid});
        end
        sample_ready = 1'b1;
        step(1);
        sample_ready = 1'b0;
        n_checks++;
        if ({sample_valid, sample} !== {1'b0, 12'hFFF}) begin
            n_fail++;
            $display("FAIL ovr_drain: valid/sample=%b/%h expected 0/fff", sample_valid, sample);
        end
        step(6);
    endtask

    task automatic test_ready_collision;
        adc_word = 16'h0123;
        sample_ready = 1'b0;
        en = 1'b1;
        step(1);                       // T
        step(65);
        n_checks++;
        if ({sample_valid, sample} !== {1'b1, 12'h123}) begin
            n_fail++;
            $display("FAIL coll_first: valid/sample=%b/%h expected 1/123", sample_valid, sample);
        end
        adc_word = 16'h0FFF;
        step(99);                      // T+164: the cycle the second result is captured
        sample_ready = 1'b1;
        step(1);                       // T+165
        sample_ready = 1'b0;
        n_checks++;
        if ({sample_valid, overrun, sample} !== {2'b10, 12'hFFF}) begin
            n_fail++;
            $display("FAIL coll_second: valid/ovr/sample=%b/%b/%h expected 1/0/fff", sample_valid, overrun, sample);
        end
        en = 1'b0;
        sample_ready = 1'b1;
        step(1);
        sample_ready = 1'b0;
        step(6);
    endtask

    task automatic test_back_to_back;
        int falls[$];
        logic pcs;
        en_b = 1'b1;
        step(1);                       // T of first frame on dut_b
        pcs = 1'b1;
        for (int c = 0; c <= 230; c++) begin
            if (pcs === 1'b1 && cs_b === 1'b0) falls.push_back(c);
            if (c == 0) begin
                n_checks++;
                if (busy_b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_busy: busy=%b expected 1", busy_b);
                end
            end
            if (c == 65) begin
                n_checks++;
                if ({valid_b, sample_b} !== {1'b1, 12'h000}) begin
                    n_fail++;
                    $display("FAIL b2b_result: valid/sample=%b/%h expected 1/000", valid_b, sample_b);
                end
            end
            pcs = cs_b;
            step(1);
        end
        n_checks++;
        if (falls.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count: %0d cs falls expected 4", falls.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (falls[i] != 71 * i) begin
                    n_fail++;
                    $display("FAIL b2b_start%0d: cs fell at T+%0d expected T+%0d", i, falls[i], 71 * i);
                end
            end
        end
        n_checks++;
        if (overrun_b !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: ovr=%b expected 0", overrun_b);
        end
        en_b = 1'b0;
        step(80);
    endtask

    task automatic test_stop_and_reset;
        int lows;
        adc_word = 16'h0555;
        sample_ready = 1'b0;
        en = 1'b1;
        step(1);                       // T
        step(20);
        en = 1'b0;
        step(45);                      // T+65
        n_checks++;
        if ({sample_valid, sample} !== {1'b1, 12'h555}) begin
            n_fail++;
            $display("FAIL stop_result: valid/sample=%b/%h expected 1/555", sample_valid, sample);
        end
        step(1);                       // T+66
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            if (cs !== 1'b1) lows++;
            step(1);
        end
        n_checks++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL stop_no_restart: cs low %0d cycles expected 0", lows);
        end
        en = 1'b1;
        step(1);                       // T'
        step(30);                      // T'+30, mid low phase of sclk
        n_checks++;
        if ({cs, sclk, sample_valid} !== 3'b001) begin
            n_fail++;
            $display("FAIL pre_rst: cs/sclk/valid=%b expected 001", {cs, sclk, sample_valid});
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({cs, sclk, sample_valid, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL async_rst: cs/sclk/valid/busy=%b expected 1100", {cs, sclk, sample_valid, busy});
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(5);
    endtask

`ifdef ADC_AVG_EN
    task automatic test_average;
        sample_ready = 1'b0;
        adc_word = 16'd100;
        en = 1'b1;
        step(1);                       // T
        step(65);
        adc_word = 16'd200;
        n_checks++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL avg_f1: valid=%b expected 0", sample_valid);
        end
        step(100);
        adc_word = 16'd300;
        step(100);
        adc_word = 16'd403;
        n_checks++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL avg_f3: valid=%b expected 0", sample_valid);
        end
        step(100);                     // T+365
        n_checks++;
        if ({sample_valid, sample} !== {1'b1, 12'd250}) begin
            n_fail++;
            $display("FAIL avg_result: valid/sample=%b/%0d expected 1/250", sample_valid, sample);
        end
        en = 1'b0;
        step(6);
    endtask
`endif

    initial begin
        test_reset();
`ifdef ADC_AVG_EN
        test_average();
`else
        test_basic_frame();
        test_overrun();
        test_ready_collision();
        test_back_to_back();
        test_stop_and_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
